// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, reset PC and bubble word,
// plus the IF/ID control bundle handed from the next-PC mux to the top.
package cpu_pkg;

   localparam int WORD_W = 32;

   localparam logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000;
   localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   typedef struct packed {
      logic load;
      logic bubble;
      logic set_err;
   } ifid_ctl_t;

   function automatic logic [WORD_W-1:0] pc_inc(
      input logic [WORD_W-1:0] pc
   );
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next_mux.sv
// Next-PC / next-state selector for the fetch stage.
// Purely combinational; the top level owns every register.
module pc_next_mux
   import cpu_pkg::*;
#(
   parameter int unsigned IMEM_WORDS = 64
) (
   input  logic [1:0]        state_i,
   input  logic [WORD_W-1:0] pc_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              flush_pend_i,
   input  logic              branch_taken_i,
   input  logic [WORD_W-1:0] branch_target_i,
   input  logic              jump_i,
   input  logic [WORD_W-1:0] jump_target_i,
   input  logic              halt_req_i,
   output logic [WORD_W-1:0] pc_d_o,
   output logic [1:0]        state_d_o,
   output logic              flush_pend_d_o,
   output ifid_ctl_t         ctl_o
);

   localparam logic [WORD_W-1:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

   logic              redir;
   logic [WORD_W-1:0] tgt;
   logic              tgt_bad;
   logic              oor;
   logic              flush_eff;

   logic sel_halt;
   logic sel_bad;
   logic sel_redir;
   logic sel_oor;
   logic sel_stall;
   logic sel_flush;
   logic sel_fetch;

   assign redir     = jump_i | branch_taken_i;
   assign tgt       = jump_i ? jump_target_i : branch_target_i;
   assign tgt_bad   = |tgt[1:0];
   assign oor       = pc_i >= PC_LIMIT;
   assign flush_eff = flush_i | flush_pend_i;

   // One-hot event select in falling priority order
   always_comb begin
      sel_halt  = halt_req_i;
      sel_bad   = !sel_halt && redir && tgt_bad;
      sel_redir = !sel_halt && redir && !tgt_bad;
      sel_oor   = !sel_halt && !redir && oor;
      sel_stall = !sel_halt && !redir && !oor && stall_i;
      sel_flush = !sel_halt && !redir && !oor && !stall_i && flush_eff;
      sel_fetch = !sel_halt && !redir && !oor && !stall_i && !flush_eff;
   end

   // Next PC, FSM state and IF/ID action
   always_comb begin
      pc_d_o         = pc_i;
      state_d_o      = state_i;
      flush_pend_d_o = flush_pend_i;
      ctl_o          = '0;
      unique case (state_i)
         S_BOOT: begin
            state_d_o = S_RUN;
         end
         S_RUN: begin
            unique case (1'b1)
               sel_halt: begin
                  state_d_o    = S_HALT;
                  ctl_o.bubble = 1'b1;
               end
               sel_bad: begin
                  state_d_o     = S_HALT;
                  ctl_o.bubble  = 1'b1;
                  ctl_o.set_err = 1'b1;
               end
               sel_redir: begin
                  pc_d_o         = tgt;
                  ctl_o.bubble   = 1'b1;
                  flush_pend_d_o = 1'b0;
               end
               sel_oor: begin
                  state_d_o     = S_HALT;
                  ctl_o.bubble  = 1'b1;
                  ctl_o.set_err = 1'b1;
               end
               sel_stall: begin
                  if (flush_i) flush_pend_d_o = 1'b1;
               end
               sel_flush: begin
                  pc_d_o         = pc_inc(pc_i);
                  ctl_o.bubble   = 1'b1;
                  flush_pend_d_o = 1'b0;
               end
               sel_fetch: begin
                  pc_d_o     = pc_inc(pc_i);
                  ctl_o.load = 1'b1;
               end
               default: begin
                  pc_d_o = pc_i;
               end
            endcase
         end
         S_HALT: begin
            flush_pend_d_o = 1'b0;
         end
         default: begin
            state_d_o    = S_HALT;
            ctl_o.bubble = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS instruction-fetch stage: PC, IF/ID register and boot/run/halt FSM.
// Redirect and hazard decisions come from pc_next_mux.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR  = cpu_pkg::NOP_INSTR,
   parameter int unsigned IMEM_WORDS = 64
) (
   input  logic        clk_CPU,
   input  logic        rst_CPU,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        halt_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        halted,
   output logic        fetch_err
);

   import cpu_pkg::*;

   logic [WORD_W-1:0] pc_q;
   logic [WORD_W-1:0] pc_d;
   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic              pend_q;
   logic              pend_d;
   logic [WORD_W-1:0] instr_q;
   logic [WORD_W-1:0] pc4_q;
   logic              valid_q;
   logic              err_q;
   ifid_ctl_t         ctl;

   pc_next_mux #(
      .IMEM_WORDS (IMEM_WORDS)
   ) u_mux (
      .state_i         (state_q),
      .pc_i            (pc_q),
      .stall_i         (stall),
      .flush_i         (flush),
      .flush_pend_i    (pend_q),
      .branch_taken_i  (branch_taken),
      .branch_target_i (branch_target),
      .jump_i          (jump),
      .jump_target_i   (jump_target),
      .halt_req_i      (halt_req),
      .pc_d_o          (pc_d),
      .state_d_o       (state_d),
      .flush_pend_d_o  (pend_d),
      .ctl_o           (ctl)
   );

   // PC, FSM and deferred-flush flag
   always_ff @(posedge clk_CPU) begin
      if (rst_CPU) begin
         pc_q    <= RESET_PC;
         state_q <= S_BOOT;
         pend_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   // IF/ID register: load fetched word, insert bubble, or hold
   always_ff @(posedge clk_CPU) begin
      if (rst_CPU) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else if (ctl.load) begin
         instr_q <= imem_rdata;
         pc4_q   <= pc_inc(pc_q);
         valid_q <= 1'b1;
      end else if (ctl.bubble) begin
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end
   end

   // Sticky fetch error, cleared only by reset
   always_ff @(posedge clk_CPU) begin
      if (rst_CPU) begin
         err_q <= 1'b0;
      end else if (ctl.set_err) begin
         err_q <= 1'b1;
      end
   end

   assign imem_addr   = {2'b00, pc_q[31:2]};
   assign if_id_instr = instr_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;
   assign halted      = (state_q == S_HALT);
   assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: IM model, expected IF/ID scoreboard
// and direct checks of flags, bubbles and PC.
module tb_instr_fetch_unit;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   logic        clk_CPU = 1'b0;
   logic        rst_CPU;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        halt_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;
   logic        fetch_err;

   logic [31:0] mem [64];
   exp_t        sb_q [$];
   int          vecs = 0;
   int          miss = 0;
   logic        prev_valid = 1'b0;
   logic [31:0] prev_pc4 = '0;

   instr_fetch_unit dut (
      .clk_CPU       (clk_CPU),
      .rst_CPU       (rst_CPU),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .halt_req      (halt_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .if_id_instr   (if_id_instr),
      .if_id_pc4     (if_id_pc4),
      .if_id_valid   (if_id_valid),
      .halted        (halted),
      .fetch_err     (fetch_err)
   );

   always #5 clk_CPU = ~clk_CPU;

   assign imem_rdata = (imem_addr < 32'd64) ? mem[imem_addr[5:0]]
                                           : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         miss++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_CPU);
      #1;
   endtask

   task automatic push(input int idx);
      exp_t e;
      e.instr = mem[idx];
      e.pc4   = 32'(idx * 4 + 4);
      sb_q.push_back(e);
   endtask

   // Scoreboard: each newly loaded IF/ID word is popped and compared
   always @(negedge clk_CPU) begin
      exp_t e;
      if (if_id_valid && !(prev_valid && if_id_pc4 == prev_pc4)) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected", if_id_pc4, 32'hFFFF_FFFF);
         end else begin
            e = sb_q.pop_front();
            check("sb_instr", if_id_instr, e.instr);
            check("sb_pc4", if_id_pc4, e.pc4);
         end
      end
      prev_valid <= if_id_valid;
      prev_pc4   <= if_id_pc4;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i * 16'h0101);
      rst_CPU = 1'b1;
      stall = 0; flush = 0; branch_taken = 0; jump = 0; halt_req = 0;
      branch_target = '0; jump_target = '0;
      tick();
      tick();
      check("rst_valid", {31'b0, if_id_valid}, 32'd0);
      check("rst_instr", if_id_instr, 32'h0);
      check("rst_pc4", if_id_pc4, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      check("rst_err", {31'b0, fetch_err}, 32'd0);
      check("rst_addr", imem_addr, 32'd0);
      rst_CPU = 1'b0;

      // T1 / T2: boot cycle, then A,B; stall holds B; then C,D
      push(0);
      push(1);
      tick();
      check("boot_valid", {31'b0, if_id_valid}, 32'd0);
      tick();
      check("first_valid", {31'b0, if_id_valid}, 32'd1);
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_instr", if_id_instr, mem[1]);
         check("stall_pc4", if_id_pc4, 32'd8);
         check("stall_addr", imem_addr, 32'd2);
      end
      stall = 1'b0;
      push(2);
      push(3);
      tick();
      tick();

      // T3: branch to 0x20 while stalled
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h20;
      tick();
      stall = 1'b0; branch_taken = 1'b0;
      check("br_valid", {31'b0, if_id_valid}, 32'd0);
      check("br_addr", imem_addr, 32'd8);
      push(8);
      tick();

      // T4: jump beats branch
      jump = 1'b1; jump_target = 32'h10;
      branch_taken = 1'b1; branch_target = 32'h40;
      tick();
      jump = 1'b0; branch_taken = 1'b0;
      check("jmp_valid", {31'b0, if_id_valid}, 32'd0);
      check("jmp_addr", imem_addr, 32'd4);
      push(4);
      tick();

      // Plain flush: slot at 0x14 becomes a bubble
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_valid", {31'b0, if_id_valid}, 32'd0);
      check("fl_addr", imem_addr, 32'd6);
      push(6);
      tick();

      // Flush under stall is deferred until stall drops
      stall = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      check("dfl_hold", if_id_instr, mem[6]);
      stall = 1'b0;
      tick();
      check("dfl_valid", {31'b0, if_id_valid}, 32'd0);
      check("dfl_addr", imem_addr, 32'd8);
      push(8);
      tick();

      // T5: misaligned branch target
      branch_taken = 1'b1; branch_target = 32'h22;
      tick();
      branch_taken = 1'b0;
      check("mis_err", {31'b0, fetch_err}, 32'd1);
      check("mis_halt", {31'b0, halted}, 32'd1);
      check("mis_valid", {31'b0, if_id_valid}, 32'd0);
      check("mis_addr", imem_addr, 32'd9);
      tick();
      tick();
      check("halt_hold", {31'b0, halted, if_id_valid}, 32'd2);
      check("halt_addr", imem_addr, 32'd9);
      rst_CPU = 1'b1;
      tick();
      rst_CPU = 1'b0;
      check("rst2_flags", {30'b0, halted, fetch_err}, 32'd0);
      check("rst2_addr", imem_addr, 32'd0);
      tick();
      push(0);
      tick();

      // T6: run off the end of IM
      for (int i = 1; i < 64; i++) begin
         push(i);
         tick();
      end
      check("end_addr", imem_addr, 32'h40);
      tick();
      check("oor_err", {31'b0, fetch_err}, 32'd1);
      check("oor_halt", {31'b0, halted}, 32'd1);
      check("oor_valid", {31'b0, if_id_valid}, 32'd0);

      // halt_req: halted without error
      rst_CPU = 1'b1;
      tick();
      rst_CPU = 1'b0;
      tick();
      push(0);
      tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("hr_halt", {31'b0, halted}, 32'd1);
      check("hr_err", {31'b0, fetch_err}, 32'd0);
      check("hr_valid", {31'b0, if_id_valid}, 32'd0);
      check("hr_addr", imem_addr, 32'd1);
      tick();
      check("hr_stay", {31'b0, halted}, 32'd1);

      @(negedge clk_CPU);
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
